gray_counter: RTL and testbench

Registered Gray-code counter that generates Gray-coded pointers/counts for consumption by the Gray-to-binary conversion stage directly downstream, typically across a clock-domain boundary. Counter state is held in binary, and the Gray output is taken straight from a flop so that exactly one output bit toggles per step. Supports up/down counting, synchronous load, and wrap or saturate behaviour at the limits.

---
 rtl/gray_pkg.sv | 16 +
 rtl/gray_counter.sv | 88 ++++++++
 tb/tb_gray_counter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the counter's reset values; latency: n/a.
// Backpressure: none (pure definitions, reused by downstream Gray-to-binary benches).
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    localparam logic RST_AT_MIN     = 1'b1;
    localparam logic RST_AT_MAX     = 1'b0;
    localparam logic RST_WRAP_PULSE = 1'b0;

    // Operates at the widest supported width; callers zero-extend and truncate back.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with load, wrap/saturate; 1-cycle latency from any control input.
// No backpressure: one step per enabled cycle, gray and flags come straight from flops.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             ena,
    input  logic             up_dn,
    input  logic             sload,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_wrap_pulse;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (sload) begin
            w_bin_next = data;
        end else if (ena) begin
            if (up_dn) begin
                if (r_bin == MAX_VAL) begin
                    if (WRAP) begin
                        w_bin_next  = MIN_VAL;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_bin_next = r_bin + 1'b1;
                end
            end else begin
                if (r_bin == MIN_VAL) begin
                    if (WRAP) begin
                        w_bin_next  = MAX_VAL;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_bin_next = r_bin - 1'b1;
                end
            end
        end
    end

    // Gray is encoded from the next binary value so the output flop changes one bit per step.
    assign w_gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_next)));

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_bin        <= '0;
            r_gray       <= '0;
            r_at_max     <= RST_AT_MAX;
            r_at_min     <= RST_AT_MIN;
            r_wrap_pulse <= RST_WRAP_PULSE;
        end else begin
            r_bin        <= w_bin_next;
            r_gray       <= w_gray_next;
            r_at_max     <= (w_bin_next == MAX_VAL);
            r_at_min     <= (w_bin_next == MIN_VAL);
            r_wrap_pulse <= w_wrap_next;
        end
    end

    assign gray       = r_gray;
    assign bin        = r_bin;
    assign at_max     = r_at_max;
    assign at_min     = r_at_min;
    assign wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share stimulus and
// are compared against an integer reference model plus directed sequences.
module tb_gray_counter;

    localparam int W    = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         sclr, ena, up_dn, sload;
    logic [W-1:0] data;

    logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
    logic         at_max_w, at_min_w, wp_w, at_max_s, at_min_s, wp_s;

    int checks = 0;
    int errors = 0;

    int           m_bin   [2];
    bit           m_wp    [2];
    logic [W-1:0] prev_gray[2];

    always #5 clock = ~clock;

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
        .clock(clock), .sclr(sclr), .ena(ena), .up_dn(up_dn), .sload(sload), .data(data),
        .gray(gray_w), .bin(bin_w), .at_max(at_max_w), .at_min(at_min_w), .wrap_pulse(wp_w)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
        .clock(clock), .sclr(sclr), .ena(ena), .up_dn(up_dn), .sload(sload), .data(data),
        .gray(gray_s), .bin(bin_s), .at_max(at_max_s), .at_min(at_min_s), .wrap_pulse(wp_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic over 0..MAXV following the counting rules.
    function automatic int model_next(input int b, input bit wrap, input bit s, input bit l,
                                      input int d, input bit e, input bit u, output bit wp);
        int n;
        wp = 1'b0;
        if (s) return 0;
        if (l) return d;
        if (!e) return b;
        n = u ? b + 1 : b - 1;
        if (n > MAXV || n < 0) begin
            if (!wrap) return b;
            wp = 1'b1;
            return (n > MAXV) ? n - (MAXV + 1) : n + (MAXV + 1);
        end
        return n;
    endfunction

    function automatic int gray2bin(input logic [W-1:0] g);
        int acc = 0;
        int res = 0;
        for (int k = W - 1; k >= 0; k--) begin
            acc = acc ^ int'(g[k]);
            res = res | (acc << k);
        end
        return res;
    endfunction

    task automatic check_all(input bit count_step);
        logic [W-1:0] g[2];
        logic [W-1:0] b[2];
        logic         amax[2], amin[2], wp[2];
        g[0] = gray_w; b[0] = bin_w; amax[0] = at_max_w; amin[0] = at_min_w; wp[0] = wp_w;
        g[1] = gray_s; b[1] = bin_s; amax[1] = at_max_s; amin[1] = at_min_s; wp[1] = wp_s;
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "w.bin"    : "s.bin",    32'(b[i]),    32'(m_bin[i]));
            chk(i == 0 ? "w.gray"   : "s.gray",   32'(g[i]),    32'(m_bin[i] ^ (m_bin[i] >> 1)));
            chk(i == 0 ? "w.at_max" : "s.at_max", 32'(amax[i]), 32'(m_bin[i] == MAXV));
            chk(i == 0 ? "w.at_min" : "s.at_min", 32'(amin[i]), 32'(m_bin[i] == 0));
            chk(i == 0 ? "w.wrap"   : "s.wrap",   32'(wp[i]),   32'(m_wp[i]));
            chk(i == 0 ? "w.g2b"    : "s.g2b",    32'(gray2bin(g[i])), 32'(m_bin[i]));
            if (count_step)
                chk(i == 0 ? "w.onebit" : "s.onebit",
                    32'($countones(g[i] ^ prev_gray[i]) <= 1), 32'd1);
            prev_gray[i] = g[i];
        end
    endtask

    task automatic step(input bit s, input bit l, input int d, input bit e, input bit u);
        sclr = s; sload = l; data = W'(d); ena = e; up_dn = u;
        @(posedge clock);
        m_bin[0] = model_next(m_bin[0], 1'b1, s, l, d, e, u, m_wp[0]);
        m_bin[1] = model_next(m_bin[1], 1'b0, s, l, d, e, u, m_wp[1]);
        @(negedge clock);
        check_all(!s && !l);
    endtask

    initial begin
        logic [W-1:0] seq_gray[5];
        int           exp_bin[3];
        seq_gray[0] = 5'b00000; seq_gray[1] = 5'b00001; seq_gray[2] = 5'b00011;
        seq_gray[3] = 5'b00010; seq_gray[4] = 5'b00110;
        sclr = 1'b0; sload = 1'b0; ena = 1'b0; up_dn = 1'b0; data = '0;
        m_bin[0] = 0; m_bin[1] = 0; m_wp[0] = 0; m_wp[1] = 0;
        @(negedge clock);

        // Reset then count up four times.
        step(1, 0, 0, 0, 0);
        chk("rst.gray", 32'(gray_w), 32'(seq_gray[0]));
        chk("rst.at_min", 32'(at_min_w), 32'd1);
        for (int k = 1; k < 5; k++) begin
            step(0, 0, 0, 1, 1);
            chk("seq.gray", 32'(gray_w), 32'(seq_gray[k]));
            chk("seq.at_min", 32'(at_min_w), 32'd0);
        end

        // Up wrap on the wrapping instance.
        exp_bin[0] = 30; exp_bin[1] = 31; exp_bin[2] = 0;
        step(0, 1, 30, 1, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step(0, 0, 0, 1, 1);
            chk("upwrap.bin", 32'(bin_w), 32'(exp_bin[k]));
            chk("upwrap.pulse", 32'(wp_w), 32'(k == 2));
            chk("upwrap.at_max", 32'(at_max_w), 32'(k == 1));
        end
        chk("upwrap.gray0", 32'(gray_w), 32'd0);

        // Saturate at zero on the saturating instance.
        step(0, 1, 1, 0, 0);
        chk("sat.bin", 32'(bin_s), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            chk("sat.bin", 32'(bin_s), 32'd0);
            chk("sat.pulse", 32'(wp_s), 32'd0);
            chk("sat.at_min", 32'(at_min_s), 32'd1);
        end

        // Down wrap from reset.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("dnwrap.bin", 32'(bin_w), 32'd31);
        chk("dnwrap.gray", 32'(gray_w), 32'b10000);
        chk("dnwrap.pulse", 32'(wp_w), 32'd1);
        chk("dnwrap.at_max", 32'(at_max_w), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("dnwrap.pulse_once", 32'(wp_w), 32'd0);

        // Priority: sclr beats sload beats ena.
        step(1, 1, 10, 1, 1);
        chk("prio.bin", 32'(bin_w), 32'd0);
        step(0, 1, 10, 1, 1);
        chk("prio.load_bin", 32'(bin_w), 32'd10);
        chk("prio.load_gray", 32'(gray_w), 32'b01111);

        // Random counting with rare loads and resets.
        for (int n = 0; n < 6000; n++) begin
            int r = int'($urandom_range(0, 255));
            step(r == 0, r == 1 || r == 2, int'($urandom_range(0, MAXV)),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
